// File: rtl/dm_dma_arbiter.sv
// Data-memory port arbiter shared by the core load/store port and a block-move engine.
// The engine copies or fills a byte region; the core wins by default, with starvation relief for the engine.
module dm_dma_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 8,
  parameter int DW           = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          core_req,
  input  logic          core_wr,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dma_go,
  input  logic [AW-1:0] dma_src,
  input  logic [AW-1:0] dma_dst,
  input  logic [AW-1:0] dma_len,
  input  logic          dma_fill,
  input  logic [DW-1:0] dma_fill_val,
  output logic          dma_busy,
  output logic          dma_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] rem_q;
  logic          fill_q;
  logic [DW-1:0] fill_val_q;
  logic [DW-1:0] buf_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          busy_q;
  logic          done_q;

  logic dma_want;
  logic starve_hit;
  logic dma_gnt;

  // Engine requests are suppressed while RESET is high so an in-flight write cannot land.
  assign dma_want   = ((state_q == S_READ) || (state_q == S_WRITE)) && !RESET;
  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
  assign dma_gnt    = dma_want && (!core_req || starve_hit);

  assign core_stall = core_req && dma_gnt;
  assign core_rdata = mem_rdata;
  assign dma_busy   = busy_q;
  assign dma_done   = done_q;
  assign dbg_state  = state_q;

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    if (dma_gnt) begin
      mem_addr  = (state_q == S_READ) ? src_q : dst_q;
      mem_wen   = (state_q == S_WRITE);
      mem_wdata = (state_q == S_WRITE) ? (fill_q ? fill_val_q : buf_q) : '0;
    end else if (core_req) begin
      mem_addr  = core_addr;
      mem_wen   = core_wr;
      mem_wdata = core_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!dma_want || dma_gnt) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      fill_q     <= 1'b0;
      fill_val_q <= '0;
      buf_q      <= '0;
      starve_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dma_go) begin
            src_q      <= dma_src;
            dst_q      <= dma_dst;
            rem_q      <= dma_len;
            fill_q     <= dma_fill;
            fill_val_q <= dma_fill_val;
            busy_q     <= 1'b1;
            if (dma_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (dma_fill) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          if (dma_gnt) begin
            buf_q   <= mem_rdata;
            src_q   <= src_q + 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (dma_gnt) begin
            dst_q <= dst_q + 1'b1;
            rem_q <= rem_q - 1'b1;
            if (rem_q == AW'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= fill_q ? S_WRITE : S_READ;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dma_arbiter.sv
// Bench for dm_dma_arbiter: behavioural 256x8 memory, reference memory model and a readback scoreboard.
module tb_dm_dma_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       core_req;
  logic       core_wr;
  logic [7:0] core_addr;
  logic [7:0] core_wdata;
  logic [7:0] core_rdata;
  logic       core_stall;
  logic       dma_go;
  logic [7:0] dma_src;
  logic [7:0] dma_dst;
  logic [7:0] dma_len;
  logic       dma_fill;
  logic [7:0] dma_fill_val;
  logic       dma_busy;
  logic       dma_done;
  logic [7:0] mem_addr;
  logic       mem_wen;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [1:0] dbg_state;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  dm_dma_arbiter #(.STARVE_LIMIT(4), .AW(8), .DW(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_go(dma_go), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_fill(dma_fill), .dma_fill_val(dma_fill_val),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / memory
  always #5 CLK = ~CLK;
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_wen) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    core_req = 0; core_wr = 0; core_addr = 0; core_wdata = 0;
    dma_go = 0; dma_src = 0; dma_dst = 0; dma_len = 0; dma_fill = 0; dma_fill_val = 0;
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic core_store(input logic [7:0] a, input logic [7:0] d);
    core_req = 1; core_wr = 1; core_addr = a; core_wdata = d;
    @(negedge CLK);
    check("st_stall", core_stall, 0);
    check("st_wen", mem_wen, 1);
    @(posedge CLK); #1;
    core_req = 0; core_wr = 0;
    ref_mem[a] = d;
  endtask

  task automatic core_load_exp(input logic [7:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    core_req = 1; core_wr = 0; core_addr = a;
    @(negedge CLK);
    check("ld_stall", core_stall, 0);
    check("ld_wen", mem_wen, 0);
    check("ld_data", core_rdata, exp_q.pop_front());
    @(posedge CLK); #1;
    core_req = 0;
  endtask

  task automatic core_load(input logic [7:0] a);
    core_load_exp(a, ref_mem[a]);
  endtask

  // Pulses go for one cycle and applies the first nb bytes of the move to the reference memory.
  task automatic start_dma(input logic [7:0] s, input logic [7:0] d, input logic [7:0] len,
                           input logic f, input logic [7:0] v, input int nb);
    logic [7:0] ps, pd;
    dma_src = s; dma_dst = d; dma_len = len; dma_fill = f; dma_fill_val = v; dma_go = 1;
    @(posedge CLK); #1;
    dma_go = 0;
    ps = s; pd = d;
    for (int i = 0; i < nb; i++) begin
      ref_mem[pd] = f ? v : ref_mem[ps];
      ps++; pd++;
    end
  endtask

  // Counts cycles after go until dma_done, and DMA writes seen (core idle).
  task automatic wait_done(output int cyc, output int wr);
    bit got;
    cyc = 0; wr = 0; got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge CLK);
      cyc++;
      if (dma_done) got = 1;
      else if (mem_wen) wr++;
    end
    if (!got) check("done_timeout", 0, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("done_pulse_end", dma_done, 0);
    check("busy_end", dma_busy, 0);
    check("state_end", dbg_state, 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int cyc, wr, run, max_run;
    logic [7:0] rs, rd, rl, a;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      ref_mem[i] = mem[i];
    end
    idle_inputs();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    @(negedge CLK);
    check("rst_busy", dma_busy, 0);
    check("rst_done", dma_done, 0);
    check("rst_stall", core_stall, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, 0);
    @(posedge CLK); #1;

    // core only
    core_store(8'd0, 8'd85);
    core_load_exp(8'd0, 8'd85);

    // copy 60..63 -> 5..8
    core_store(8'd60, 8'd240); core_store(8'd61, 8'd7);
    core_store(8'd62, 8'd142); core_store(8'd63, 8'd7);
    start_dma(8'd60, 8'd5, 8'd4, 1'b0, 8'd0, 4);
    wait_done(cyc, wr);
    check("copy_cycles", cyc, 9);
    check("copy_writes", wr, 4);
    core_load_exp(8'd5, 8'd240); core_load_exp(8'd6, 8'd7);
    core_load_exp(8'd7, 8'd142); core_load_exp(8'd8, 8'd7);

    // fill with wrap
    start_dma(8'd0, 8'hFE, 8'd3, 1'b1, 8'hAA, 3);
    wait_done(cyc, wr);
    check("fill_cycles", cyc, 4);
    check("fill_writes", wr, 3);
    core_load_exp(8'hFE, 8'hAA); core_load_exp(8'hFF, 8'hAA); core_load_exp(8'h00, 8'hAA);
    core_load(8'h01);

    // starvation: core reads addr 200 continuously during a len=1 copy
    core_req = 1; core_wr = 0; core_addr = 8'd200;
    start_dma(8'd50, 8'd210, 8'd1, 1'b0, 8'd0, 1);
    for (int p = 0; p < 2; p++) begin
      repeat (4) exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
    end
    run = 0; max_run = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      check("starve_stall", core_stall, exp_q.pop_front());
      if (!core_stall) check("starve_rdata", core_rdata, ref_mem[200]);
      if (c == 10) check("starve_wen", mem_wen, 1);
      run = core_stall ? run + 1 : 0;
      if (run > max_run) max_run = run;
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("starve_done", dma_done, 1);
    check("starve_maxrun", max_run, 1);
    @(posedge CLK); #1;
    core_req = 0;
    core_load(8'd210);

    // zero length
    start_dma(8'd7, 8'd9, 8'd0, 1'b0, 8'd0, 0);
    wait_done(cyc, wr);
    check("len0_cycles", cyc, 1);
    check("len0_writes", wr, 0);

    // go while busy is ignored
    start_dma(8'd20, 8'd120, 8'd4, 1'b0, 8'd0, 4);
    dma_go = 1; dma_dst = 8'd140; dma_src = 8'd30;
    @(posedge CLK); #1;
    dma_go = 0;
    wait_done(cyc, wr);
    check("busy_go_cycles", cyc, 8);
    check("busy_go_writes", wr, 4);
    for (int i = 0; i < 4; i++) begin
      a = 8'(120 + i); core_load(a);
      a = 8'(140 + i); core_load(a);
    end

    // reset during the third write of a 4-byte copy
    start_dma(8'd100, 8'd150, 8'd4, 1'b0, 8'd0, 2);
    repeat (5) @(posedge CLK);
    #1 RESET = 1;
    @(negedge CLK);
    check("rst_mid_state", dbg_state, 2);
    check("rst_mid_wen", mem_wen, 0);
    @(posedge CLK); #1;
    RESET = 0;
    @(negedge CLK);
    check("rst_mid_busy", dma_busy, 0);
    check("rst_mid_done", dma_done, 0);
    check("rst_mid_idle", dbg_state, 0);
    @(posedge CLK); #1;
    core_store(8'd33, 8'h5A);
    core_load(8'd33);
    for (int i = 0; i < 4; i++) begin
      a = 8'(150 + i); core_load(a);
    end

    // random copies and fills, core idle
    for (int t = 0; t < 4; t++) begin
      rs = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(1, 6));
      start_dma(rs, rd, rl, 1'(t & 1), 8'($urandom_range(0, 255)), int'(rl));
      wait_done(cyc, wr);
      check("rnd_writes", wr, int'(rl));
      a = rd;
      for (int i = 0; i < int'(rl); i++) begin
        core_load(a);
        a++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_dma_arbiter.md
Name: dm_dma_arbiter

Overview:
- Shares the single-port 256x8 data memory between the processor core's load/store port and an internal block-move engine.
- The engine copies or fills a byte region of data memory.
- Lets a program preload or relocate tables without test-bench back-door writes to the memory array.
- Sits between the datapath and the data memory, inside the top level.

Parameters:
STARVE_LIMIT, 4, consecutive DMA-denied cycles after which DMA is forced one grant.
AW, 8, memory address width (256 bytes).
DW, 8, data width.

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
core_req  in  1  core requests a memory access this cycle
core_wr  in  1  1 = store, 0 = load (valid with core_req)
core_addr  in  AW  core address
core_wdata  in  DW  core store data
core_rdata  out  DW  load data (mem_rdata passthrough)
core_stall  out  1  core access not granted this cycle; core must hold request
dma_go  in  1  start pulse, sampled only in IDLE
dma_src  in  AW  source start address (ignored in fill mode)
dma_dst  in  AW  destination start address
dma_len  in  AW  byte count, 0 allowed
dma_fill  in  1  1 = write dma_fill_val to every destination byte
dma_fill_val  in  DW  fill byte
dma_busy  out  1  engine active
dma_done  out  1  one-cycle pulse on completion
mem_addr  out  AW  memory address
mem_wen  out  1  memory write enable
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory combinational read data

Behaviour:
- Memory model: combinational read of mem_addr; write on CLK edge when mem_wen=1.
- Reset: all registers cleared. Outputs after reset: FSM=IDLE, dma_busy=0, dma_done=0, core_stall=0, mem_wen=0, mem_addr=0, mem_wdata=0, starve count=0.
- FSM states:
  - IDLE: dma_go=1 latches src/dst/len/fill/fill_val.
    - len=0 -> DONE.
    - fill=1 -> WRITE.
    - otherwise -> READ.
  - READ: needs DMA grant. On grant, latch mem_rdata at src into buffer, src+1, -> WRITE. Without grant, hold.
  - WRITE: needs DMA grant. On grant, write buffer (or fill_val) to dst, dst+1, remaining-1.
    - remaining reaches 0 -> DONE.
    - otherwise -> READ (copy) or WRITE (fill).
    - Without grant, hold.
  - DONE: dma_done=1 for exactly one cycle -> IDLE.
- dma_busy=1 in READ, WRITE and DONE.
- dma_go outside IDLE is ignored; there is no queueing.
- Arbitration is combinational, per cycle:
  - DMA wants the port in READ/WRITE.
  - The core wins by default.
  - DMA wins if core_req=0, or if starve count == STARVE_LIMIT.
- Starve count:
  - Increments on each cycle DMA wants the port and loses.
  - Clears on a DMA grant, or when DMA does not want the port.
- core_stall = core_req & DMA granted. When the core is granted, core_stall=0 the same cycle, so a load completes in zero extra cycles.
- mem_addr/mem_wen/mem_wdata select from the granted requester.
  - Core: mem_wen=core_req&core_wr.
  - DMA: mem_wen=1 only in WRITE.
  - Nobody granted: mem_wen=0.
- core_rdata = mem_rdata at all times; it is valid only when core_req & !core_stall.
- Address arithmetic is modulo 256: 8'hFF+1 wraps to 8'h00 for both src and dst.
- Overlapping copy is performed strictly ascending, byte by byte. If dst>src and the regions overlap, earlier written bytes propagate; this is intended.
- RESET mid-transfer: engine returns to IDLE the next edge, with no further writes and no dma_done pulse. Bytes already written remain.

Test Plan:
- Core only: store 8'd85 to addr 0, then load addr 0 with no DMA active -> mem_wen one cycle, core_rdata=85, core_stall=0 throughout.
- Copy src=60, dst=5, len=4, memory 60..63={240,7,142,7}, core idle -> 8 grant cycles, dma_done pulses at cycle 9, mem[5..8]={240,7,142,7}.
- Fill dst=8'hFE, len=3, val=8'hAA -> mem[FE], mem[FF], mem[00]=AA (wrap), 3 write cycles then dma_done.
- Starvation: core_req held 1 continuously during a copy with len=1, STARVE_LIMIT=4 -> DMA granted on the 5th cycle with core_stall=1 that cycle only, then 4 denied cycles, then a forced grant again. Core stall never exceeds 1 consecutive cycle.
- len=0 with dma_go -> no mem_wen from DMA, dma_done one cycle after go, then back to IDLE. A dma_go while busy on a len=4 copy is ignored: exactly 4 bytes are written.
- RESET asserted in WRITE after 2 of 4 bytes copied -> only 2 destination bytes changed, dma_busy=0 and dma_done=0 next cycle, core access works immediately after.
